// File: rtl/soc_clk_rst_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : soc_clk_rst_gen
// Purpose  : Programmable divided SoC clock with a glitch-free divisor-change
//            handshake, a rise strobe, and a SoC reset released on a falling
//            edge of the divided clock.
// Revision : 1.0
// ============================================================================
module soc_clk_rst_gen #(
    parameter int DIV_W       = 28,
    parameter int DEFAULT_DIV = 5000,
    parameter int RST_HOLD    = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic [DIV_W-1:0] cur_div_o,
    output logic             clk_o,
    output logic             clk_en_o,
    output logic             soc_rst_no
);

    localparam logic [DIV_W-1:0] c_DEF_DIV  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_MIN_DIV  = DIV_W'(2);
    localparam logic [DIV_W-1:0] c_ONE      = DIV_W'(1);
    localparam int               c_RCW      = $clog2(RST_HOLD + 1);
    localparam logic [c_RCW-1:0] c_RST_HOLD = c_RCW'(RST_HOLD);
    localparam logic [c_RCW-1:0] c_RST_ONE  = c_RCW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] r_pend_q;
    logic             r_pend_v;
    logic [c_RCW-1:0] r_rst_cnt;
    logic             r_clk;
    logic             r_clk_en;
    logic             r_soc_rst_n;

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic             w_wrap;
    logic             w_apply;
    logic             w_accept;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_div_eff;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_req_div;
    logic             w_hold_done;
    logic             w_fall;

    always_comb begin
        w_wrap      = (r_cnt == (r_div_q - c_ONE));
        w_apply     = w_wrap && r_pend_v;
        w_accept    = div_valid_i && !r_pend_v;
        w_cnt_next  = w_wrap ? '0 : (r_cnt + c_ONE);
        // A pending divisor takes over exactly at the period boundary so the
        // new period is shaped entirely by the new value.
        w_div_eff   = w_apply ? r_pend_q : r_div_q;
        w_half      = w_div_eff >> 1;
        w_req_div   = (div_i < c_MIN_DIV) ? c_MIN_DIV : div_i;
        w_hold_done = (r_rst_cnt == c_RST_HOLD);
        w_fall      = (w_cnt_next == w_half);
    end

    // ------------------------------------------------------------------
    // Period counter and divided clock
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt    <= c_DEF_DIV - c_ONE;
            r_clk    <= 1'b0;
            r_clk_en <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_clk    <= (w_cnt_next < w_half);
            r_clk_en <= (w_cnt_next == '0);
        end
    end

    // ------------------------------------------------------------------
    // Divisor handshake: accept and apply are mutually exclusive because
    // acceptance needs an empty slot and apply needs a full one.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_div_q  <= c_DEF_DIV;
            r_pend_q <= c_DEF_DIV;
            r_pend_v <= 1'b0;
        end else begin
            if (w_apply) begin
                r_div_q  <= r_pend_q;
                r_pend_v <= 1'b0;
            end else if (w_accept) begin
                r_pend_q <= w_req_div;
                r_pend_v <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // SoC reset sequencing: count rising strobes, release on the next fall.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_rst_cnt   <= '0;
            r_soc_rst_n <= 1'b0;
        end else begin
            if (r_clk_en && !w_hold_done) begin
                r_rst_cnt <= r_rst_cnt + c_RST_ONE;
            end
            if (w_hold_done && w_fall) begin
                r_soc_rst_n <= 1'b1;
            end
        end
    end

    assign div_ready_o = !r_pend_v;
    assign cur_div_o   = r_div_q;
    assign clk_o       = r_clk;
    assign clk_en_o    = r_clk_en;
    assign soc_rst_no  = r_soc_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_soc_clk_rst_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_soc_clk_rst_gen
// Purpose  : Directed self-checking bench for soc_clk_rst_gen (two instances:
//            default parameters, and DEFAULT_DIV=4 / RST_HOLD=2).
// Revision : 1.0
// ============================================================================
module tb_soc_clk_rst_gen;

    localparam int DIV_W = 28;

    logic             clk = 1'b0;
    logic             rst_a, rst_b;
    logic [DIV_W-1:0] div_a, div_b;
    logic             val_a, val_b;
    logic             rdy_a, rdy_b;
    logic [DIV_W-1:0] cur_a, cur_b;
    logic             dclk_a, dclk_b;
    logic             en_a, en_b;
    logic             soc_a, soc_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    soc_clk_rst_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(5000), .RST_HOLD(4)) dut_a (
        .clock_i(clk), .reset_i(rst_a), .div_i(div_a), .div_valid_i(val_a),
        .div_ready_o(rdy_a), .cur_div_o(cur_a), .clk_o(dclk_a),
        .clk_en_o(en_a), .soc_rst_no(soc_a)
    );

    soc_clk_rst_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(4), .RST_HOLD(2)) dut_b (
        .clock_i(clk), .reset_i(rst_b), .div_i(div_b), .div_valid_i(val_b),
        .div_ready_o(rdy_b), .cur_div_o(cur_b), .clk_o(dclk_b),
        .clk_en_o(en_b), .soc_rst_no(soc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en_a(input int budget, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!en_a && n < budget);
        chk(tag, 32'(en_a), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat_c, pat_e;
        int         zero_seen, n;

        rst_a = 1'b1; rst_b = 1'b1;
        div_a = '0;   div_b = '0;
        val_a = 1'b0; val_b = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_cur_a",   32'(cur_a),  32'd5000);
        chk("rst_rdy_a",   32'(rdy_a),  32'd1);
        chk("rst_clk_a",   32'(dclk_a), 32'd0);
        chk("rst_en_a",    32'(en_a),   32'd0);
        chk("rst_soc_a",   32'(soc_a),  32'd0);
        chk("rst_cur_b",   32'(cur_b),  32'd4);
        chk("rst_soc_b",   32'(soc_b),  32'd0);

        // Reset release sequence, DEFAULT_DIV=4 RST_HOLD=2
        rst_b = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 1) begin
                chk("b_e1_en",  32'(en_b),   32'd1);
                chk("b_e1_clk", 32'(dclk_b), 32'd1);
            end
            if (e == 2) chk("b_e2_en", 32'(en_b), 32'd0);
            if (e == 5) chk("b_e5_en", 32'(en_b), 32'd1);
            if (e == 6) begin
                chk("b_e6_soc", 32'(soc_b),  32'd0);
                chk("b_e6_clk", 32'(dclk_b), 32'd1);
            end
            if (e == 7) begin
                chk("b_e7_soc", 32'(soc_b),  32'd1);
                chk("b_e7_clk", 32'(dclk_b), 32'd0);
            end
        end
        div_b = 28'd6; val_b = 1'b1;
        tick();
        val_b = 1'b0;
        chk("b_rdy_after_acc", 32'(rdy_b), 32'd0);
        zero_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!soc_b) zero_seen++;
        end
        chk("b_soc_stays", 32'(zero_seen), 32'd0);
        chk("b_cur_div6",  32'(cur_b),     32'd6);

        // Default divisor after release
        rst_a = 1'b0;
        tick();
        chk("a_e1_clk", 32'(dclk_a), 32'd1);
        chk("a_e1_en",  32'(en_a),   32'd1);
        n = 1; zero_seen = 0;
        for (int i = 2; i <= 5000; i++) begin
            tick();
            n += int'(dclk_a);
            zero_seen += int'(en_a);
        end
        chk("a_high_cycles", 32'(n),         32'd2500);
        chk("a_no_extra_en", 32'(zero_seen), 32'd0);
        tick();
        chk("a_period_en", 32'(en_a), 32'd1);

        // Odd divisor 5
        div_a = 28'd5; val_a = 1'b1;
        tick();
        val_a = 1'b0;
        chk("a_rdy_pend5", 32'(rdy_a), 32'd0);
        chk("a_cur_old",   32'(cur_a), 32'd5000);
        wait_en_a(6000, "a_apply5_to");
        chk("a_cur5", 32'(cur_a), 32'd5);
        chk("a_rdy5", 32'(rdy_a), 32'd1);
        pat_c = {9'd0, dclk_a}; pat_e = {9'd0, en_a};
        for (int i = 0; i < 9; i++) begin
            tick();
            pat_c = {pat_c[8:0], dclk_a};
            pat_e = {pat_e[8:0], en_a};
        end
        chk("a_div5_clk", 32'(pat_c), 32'b1100011000);
        chk("a_div5_en",  32'(pat_e), 32'b1000010000);

        // div_i = 1 clamps to 2
        div_a = 28'd1; val_a = 1'b1;
        tick();
        val_a = 1'b0;
        wait_en_a(20, "a_apply2_to");
        chk("a_cur_clamp2", 32'(cur_a), 32'd2);
        pat_c = {9'd0, dclk_a}; pat_e = {9'd0, en_a};
        for (int i = 0; i < 3; i++) begin
            tick();
            pat_c = {pat_c[8:0], dclk_a};
            pat_e = {pat_e[8:0], en_a};
        end
        chk("a_div2_clk", 32'(pat_c), 32'b1010);
        chk("a_div2_en",  32'(pat_e), 32'b1010);

        // Accept in the wrap cycle: applied one period later
        div_a = 28'd7; val_a = 1'b1;
        tick();
        val_a = 1'b0;
        chk("a_wrapacc_en",  32'(en_a),  32'd1);
        chk("a_wrapacc_cur", 32'(cur_a), 32'd2);
        chk("a_wrapacc_rdy", 32'(rdy_a), 32'd0);
        tick();
        chk("a_wrapacc_mid", 32'(cur_a), 32'd2);
        tick();
        chk("a_wrapacc_cur7", 32'(cur_a), 32'd7);
        chk("a_wrapacc_en7",  32'(en_a),  32'd1);
        chk("a_wrapacc_rdy7", 32'(rdy_a), 32'd1);

        // Second request while not ready is ignored
        div_a = 28'd3; val_a = 1'b1;
        tick();
        chk("a_req1_rdy", 32'(rdy_a), 32'd0);
        div_a = 28'd9;
        tick();
        chk("a_req2_blocked", 32'(rdy_a), 32'd0);
        val_a = 1'b0;
        wait_en_a(20, "a_apply3_to");
        chk("a_first_wins", 32'(cur_a), 32'd3);
        n = 0;
        do begin
            tick();
            n++;
        end while (!en_a && n < 20);
        chk("a_period3", 32'(n), 32'd3);
        chk("a_still3",  32'(cur_a), 32'd3);

        // Async reset mid-period with divisor 10 and a pending request
        div_a = 28'd10; val_a = 1'b1;
        tick();
        val_a = 1'b0;
        wait_en_a(20, "a_apply10_to");
        chk("a_cur10", 32'(cur_a), 32'd10);
        div_a = 28'd8; val_a = 1'b1;
        tick();
        val_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("a_pend8_rdy", 32'(rdy_a), 32'd0);
        chk("a_soc_up",    32'(soc_a), 32'd1);
        #2 rst_a = 1'b1;
        #1;
        chk("a_arst_cur", 32'(cur_a),  32'd5000);
        chk("a_arst_rdy", 32'(rdy_a),  32'd1);
        chk("a_arst_clk", 32'(dclk_a), 32'd0);
        chk("a_arst_en",  32'(en_a),   32'd0);
        chk("a_arst_soc", 32'(soc_a),  32'd0);
        tick();
        rst_a = 1'b0;
        tick();
        chk("a_rel_clk", 32'(dclk_a), 32'd1);
        chk("a_rel_en",  32'(en_a),   32'd1);
        chk("a_rel_rdy", 32'(rdy_a),  32'd1);
        wait_en_a(5100, "a_rel_wrap_to");
        chk("a_pend_lost", 32'(cur_a), 32'd5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_clk_rst_gen.md
# soc_clk_rst_gen

Clock and reset generation stage that sits directly upstream of the SoC top in the Verilator harness. It derives the SoC clock from the fast harness clock through a programmable divider and issues a glitch-free divisor-change handshake. It also produces a clock-enable strobe and a SoC reset that releases cleanly on a falling edge of the divided clock. It replaces the ad-hoc divider in the harness top and feeds both the SoC and the JTAG DPI clock inputs.

## Interface
- DIV_W, 28, width of divisor and period counter
- DEFAULT_DIV, 5000, divisor loaded at reset (must be >= 2)
- RST_HOLD, 4, number of divided-clock rising edges the SoC reset is held after release (>= 1)

- clock_i  in  1  fast harness clock; all logic on its rising edge
- reset_i  in  1  asynchronous, active-high reset
- div_i  in  DIV_W  requested divisor
- div_valid_i  in  1  divisor request valid
- div_ready_o  out  1  divisor request can be accepted
- cur_div_o  out  DIV_W  divisor currently in effect
- clk_o  out  1  divided clock (registered)
- clk_en_o  out  1  one-cycle strobe in clock_i domain, high in the cycle clk_o rises
- soc_rst_no  out  1  active-low reset to the SoC

## Operation
- Registers: cnt (DIV_W), div_q, pend_q + pend_v, rst_cnt (saturating at RST_HOLD), clk_o, clk_en_o, soc_rst_no.
- Reset values: cnt = DEFAULT_DIV-1, div_q = cur_div_o = DEFAULT_DIV, pend_v = 0 (div_ready_o = 1), clk_o = 0, clk_en_o = 0, rst_cnt = 0, soc_rst_no = 0.
- Period counter: wrap = (cnt == div_q-1). cnt_next = wrap ? 0 : cnt+1. div_eff = (wrap && pend_v) ? pend_q : div_q.
- clk_o <= (cnt_next < div_eff>>1). clk_en_o <= (cnt_next == 0). clk_o is therefore high for floor(div/2) cycles and low for div - floor(div/2) cycles.
- Divisor handshake: div_ready_o = !pend_v. On valid && ready: pend_q <= max(div_i, 2), pend_v <= 1. Values 0 and 1 are clamped to 2.
- Apply at wrap only: when wrap && pend_v, div_q <= pend_q and pend_v <= 0. The new period starts with the new divisor, so no short or long pulse is produced.
- Accept and wrap in the same cycle: the accepted value becomes pending. It is applied at the next wrap, not the current one.
- div_valid_i while not ready: ignored. The request must be held by the source.
- SoC reset: rst_cnt increments on each clock_i edge where clk_en_o is registered high, and saturates at RST_HOLD.
- soc_rst_no <= 1 at the first edge where rst_cnt == RST_HOLD and cnt_next == div_eff>>1. This is the falling edge of clk_o following the RST_HOLD-th rising edge. It then stays 1 until reset_i.
- Divisor changes do not re-assert soc_rst_no.
- reset_i mid-operation: all registers immediately take their reset values, and any pending divisor is discarded.

## Timing
- First clock_i edge after reset_i deasserts: cnt = 0, clk_o = 1, clk_en_o = 1.
- Period of clk_o = div_q clock_i cycles. clk_en_o is high exactly one cycle per period.
- Divisor change latency: from acceptance to the first clk_o rise at the new rate is at most div_q (old) cycles. div_ready_o returns to 1 on the edge after the apply.
- All outputs are registered except div_ready_o, which is a direct inverse of the pend_v register.

## Test plan
- Reset/default: hold reset_i, check all reset values. Release and check clk_o rises on the first edge with clk_en_o = 1, and a period of 5000 with 2500 cycles high.
- Odd divisor: apply div_i = 5 during idle. After the apply wrap, clk_o is high 2 and low 3 cycles, repeating, with clk_en_o every 5 cycles. cur_div_o = 5.
- Reset release with DEFAULT_DIV = 4 and RST_HOLD = 2:
  - clk_en_o pulses on edges 1 and 5.
  - soc_rst_no goes to 1 on edge 7, when clk_o falls.
  - soc_rst_no stays 1 across a later divisor change.
- Handshake boundaries:
  - div_i = 1 is stored as 2, giving clk_o that toggles every cycle.
  - A request accepted in the wrap cycle is applied one full period later.
  - A second request while div_ready_o = 0 is not taken; the first value wins.
- Async reset mid-period: with divisor 10, assert reset_i at cnt = 6 with a divisor pending. Outputs return to reset values immediately and the pending value is lost. After release the divisor is DEFAULT_DIV again.
